// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Results are computed at launch and committed only after the fixed busy latency.
module mult_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  MDUcal,
   input  logic [3:0]  MDUwrite,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        IntReq,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic {StIdle, StBusy} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] p_hi, p_lo;

   logic        op_valid, is_div;
   logic [63:0] prod_s, prod_u;
   logic [31:0] div_b, abs_a, abs_b;
   logic [31:0] sq, sr, q_s, r_s, q_u, r_u;
   logic [31:0] res_hi, res_lo;

   assign op_valid = (MDUcal >= 4'd1) && (MDUcal <= 4'd4);
   assign is_div   = (MDUcal == 4'd3) || (MDUcal == 4'd4);

   // Low 64 bits of the product of the sign-extended operands is the signed product.
   assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
   assign prod_u = {32'd0, A} * {32'd0, B};

   // A zero divisor is replaced by 1 so the dividers never see it; the result is discarded.
   assign div_b = (B == 32'd0) ? 32'd1 : B;
   assign abs_a = A[31] ? (32'd0 - A) : A;
   assign abs_b = div_b[31] ? (32'd0 - div_b) : div_b;
   assign sq    = abs_a / abs_b;
   assign sr    = abs_a % abs_b;
   assign q_s   = (A[31] ^ div_b[31]) ? (32'd0 - sq) : sq;
   assign r_s   = A[31] ? (32'd0 - sr) : sr;
   assign q_u   = A / div_b;
   assign r_u   = A % div_b;

   always_comb begin
      res_hi = HI;
      res_lo = LO;
      case (MDUcal)
         4'd1: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         4'd2: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         4'd3: begin
            if (B != 32'd0) begin
               res_hi = r_s;
               res_lo = q_s;
            end
         end
         4'd4: begin
            if (B != 32'd0) begin
               res_hi = r_u;
               res_lo = q_u;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= StIdle;
         cnt   <= 4'd0;
         busy  <= 1'b0;
         HI    <= 32'd0;
         LO    <= 32'd0;
         p_hi  <= 32'd0;
         p_lo  <= 32'd0;
      end else begin
         unique case (state)
            StIdle: begin
               if (!IntReq) begin
                  if (start && op_valid) begin
                     p_hi  <= res_hi;
                     p_lo  <= res_lo;
                     cnt   <= is_div ? 4'd10 : 4'd5;
                     busy  <= 1'b1;
                     state <= StBusy;
                  end else if (!start) begin
                     if (MDUwrite == 4'd1) HI <= A;
                     else if (MDUwrite == 4'd2) LO <= A;
                  end
               end
            end
            StBusy: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  HI    <= p_hi;
                  LO    <= p_lo;
                  busy  <= 1'b0;
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model checked every cycle,
// directed literal cases plus a randomized run.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset, start, IntReq;
   logic [3:0]  MDUcal, MDUwrite;
   logic [31:0] A, B;
   logic        busy;
   logic [31:0] HI, LO;

   int passed = 0;
   int total  = 0;

   // Reference model state
   int          m_rem;
   logic        m_keep;
   logic [31:0] m_hi, m_lo, m_phi, m_plo;

   mult_div_unit dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .MDUcal   (MDUcal),
      .MDUwrite (MDUwrite),
      .A        (A),
      .B        (B),
      .IntReq   (IntReq),
      .busy     (busy),
      .HI       (HI),
      .LO       (LO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic model_step();
      longint          sa, sb, sp, sq, sr;
      longint unsigned ua, ub, up;
      if (!reset) begin
         m_rem = 0;
         m_hi  = 0;
         m_lo  = 0;
         return;
      end
      if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0 && !m_keep) begin
            m_hi = m_phi;
            m_lo = m_plo;
         end
      end else if (!IntReq) begin
         if (start && MDUcal >= 1 && MDUcal <= 4) begin
            sa = longint'($signed(A));
            sb = longint'($signed(B));
            ua = A;
            ub = B;
            m_keep = 1'b0;
            case (MDUcal)
               4'd1: begin
                  sp = sa * sb;
                  m_phi = sp[63:32];
                  m_plo = sp[31:0];
               end
               4'd2: begin
                  up = ua * ub;
                  m_phi = up[63:32];
                  m_plo = up[31:0];
               end
               4'd3: begin
                  if (B == 0) m_keep = 1'b1;
                  else begin
                     sq = sa / sb;
                     sr = sa % sb;
                     m_plo = sq[31:0];
                     m_phi = sr[31:0];
                  end
               end
               default: begin
                  if (B == 0) m_keep = 1'b1;
                  else begin
                     m_plo = A / B;
                     m_phi = A % B;
                  end
               end
            endcase
            m_rem = (MDUcal <= 2) ? 5 : 10;
         end else if (!start) begin
            if (MDUwrite == 4'd1) m_hi = A;
            else if (MDUwrite == 4'd2) m_lo = A;
         end
      end
   endtask

   // One clock: apply inputs, step the model at the edge, compare just after it.
   task automatic cycle(input logic st, input logic [3:0] cal, input logic [3:0] wr,
                        input logic [31:0] a, input logic [31:0] b, input logic irq,
                        input logic rst);
      start = st; MDUcal = cal; MDUwrite = wr; A = a; B = b; IntReq = irq; reset = rst;
      @(posedge clk);
      model_step();
      #1;
      chk("busy", {31'd0, busy}, {31'd0, m_rem > 0});
      chk("HI", HI, m_hi);
      chk("LO", LO, m_lo);
   endtask

   task automatic idle();
      cycle(1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
   endtask

   // Launch one op and count busy cycles, bounded.
   task automatic run_op(input logic [3:0] cal, input logic [31:0] a, input logic [31:0] b,
                         input int exp_len);
      int n = 0;
      cycle(1'b1, cal, 4'd0, a, b, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         if (!busy) break;
         n++;
         idle();
      end
      chk("busy_len", n, exp_len);
   endtask

   initial begin
      m_rem = 0; m_keep = 0; m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0;
      cycle(1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      cycle(1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_HI", HI, 32'd0);
      chk("rst_LO", LO, 32'd0);

      run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 5);
      chk("smul_HI", HI, 32'hFFFF_FFFF);
      chk("smul_LO", LO, 32'hFFFF_FFFA);
      run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 5);
      chk("umul_HI", HI, 32'h0000_0002);
      chk("umul_LO", LO, 32'hFFFF_FFFA);
      run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 10);
      chk("sdiv_LO", LO, 32'hFFFF_FFFD);
      chk("sdiv_HI", HI, 32'hFFFF_FFFF);
      run_op(4'd4, 32'hFFFF_FFF9, 32'd2, 10);
      chk("udiv_LO", LO, 32'h7FFF_FFFC);
      chk("udiv_HI", HI, 32'h0000_0001);

      // Move-to, then divide by zero leaves HI/LO alone
      cycle(1'b0, 4'd0, 4'd1, 32'h1234_5678, 32'd0, 1'b0, 1'b1);
      cycle(1'b0, 4'd0, 4'd2, 32'h1234_5678, 32'd0, 1'b0, 1'b1);
      chk("mt_busy", {31'd0, busy}, 32'd0);
      run_op(4'd3, 32'h0000_0064, 32'd0, 10);
      chk("div0_HI", HI, 32'h1234_5678);
      chk("div0_LO", LO, 32'h1234_5678);
      run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
      chk("ovf_LO", LO, 32'h8000_0000);
      chk("ovf_HI", HI, 32'h0000_0000);

      // start+MDUwrite during busy cycle 2 are ignored
      cycle(1'b1, 4'd2, 4'd0, 32'd3, 32'd4, 1'b0, 1'b1);
      idle();
      cycle(1'b1, 4'd2, 4'd1, 32'd5, 32'd6, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) idle();
      chk("ign_HI", HI, 32'd0);
      chk("ign_LO", LO, 32'd12);

      // IntReq cancels start and move-to
      cycle(1'b1, 4'd1, 4'd0, 32'd7, 32'd7, 1'b1, 1'b1);
      chk("irq_busy", {31'd0, busy}, 32'd0);
      cycle(1'b0, 4'd0, 4'd2, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b1);
      chk("irq_LO", LO, 32'd12);

      // Reset during busy cycle 3 of a div abandons it
      cycle(1'b1, 4'd4, 4'd0, 32'd100, 32'd7, 1'b0, 1'b1);
      idle();
      idle();
      cycle(1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 12; i++) idle();
      chk("mrst_HI", HI, 32'd0);
      chk("mrst_LO", LO, 32'd0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [31:0] ra, rb;
         logic        rs, rr, ri;
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'hFFFF_FFFF;
            3: rb = $urandom_range(1, 9);
            default: ;
         endcase
         rs = ($urandom_range(0, 3) == 0);
         ri = ($urandom_range(0, 7) == 0);
         rr = ($urandom_range(0, 63) != 0);
         cycle(rs, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 3)), ra, rb, ri, rr);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock `clk` (input, 1): all state updates on the rising edge.
REQ-002 The block SHALL have reset `reset` (input, 1): synchronous, active-low; reset==0 at a rising edge resets the block.
REQ-003 The block SHALL have input `start` (1): launches a multiply/divide operation; driven by the decoder `start` field from the E stage.
REQ-004 The block SHALL have input `MDUcal` (4): operation select; 4'd1 = sign_mult, 4'd2 = zero_mult, 4'd3 = sign_div, 4'd4 = zero_div; any other value is a no-op.
REQ-005 The block SHALL have input `MDUwrite` (4): move-to select; 4'd1 = whi (mthi), 4'd2 = wlo (mtlo); any other value is a no-op.
REQ-006 The block SHALL have input `A` (32): rs operand, already forwarded.
REQ-007 The block SHALL have input `B` (32): rt operand, already forwarded.
REQ-008 The block SHALL have input `IntReq` (1): exception/interrupt cancel; when 1, this cycle's start and MDUwrite are discarded.
REQ-009 The block SHALL have output `busy` (1): registered; 1 while an operation is in flight.
REQ-010 The block SHALL have output `HI` (32): registered HI register value.
REQ-011 The block SHALL have output `LO` (32): registered LO register value.

Function
REQ-012 The block SHALL be a two-state FSM: IDLE, BUSY; a 4-bit down-counter `cnt`; pending result registers `pHI`, `pLO`.
REQ-013 In IDLE, when start==1, IntReq==0 and MDUcal is in 1..4 at edge T, the block SHALL compute the result from A/B sampled at T into pHI/pLO, load cnt (5 for mult, 10 for div) and enter BUSY.
REQ-014 `busy` SHALL be 1 for exactly 5 cycles after a mult start and exactly 10 cycles after a div start, beginning the cycle after edge T.
REQ-015 In BUSY, each edge SHALL decrement cnt; on the edge where cnt==1, the block SHALL copy pHI->HI and pLO->LO, clear busy and return to IDLE. HI/LO SHALL be visible in the first cycle with busy==0.
REQ-016 sign_mult/zero_mult SHALL form the 64-bit signed/unsigned product; HI = [63:32], LO = [31:0].
REQ-017 sign_div/zero_div SHALL set LO = quotient and HI = remainder. Signed division SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend (A).
REQ-018 Signed A=0x80000000, B=0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-019 Division with B==0 SHALL still occupy 10 busy cycles and SHALL leave HI/LO unchanged.
REQ-020 In IDLE, with start==0 and IntReq==0: MDUwrite==1 SHALL write A to HI at the edge; MDUwrite==2 SHALL write A to LO; no busy cycles.
REQ-021 If start and MDUwrite are both active in one cycle, start SHALL take priority and MDUwrite is ignored.
REQ-022 start and MDUwrite arriving while BUSY SHALL be ignored; the hazard unit stalls on start|busy, so this is a protection case only.
REQ-023 IntReq==1 SHALL NOT affect an operation already in BUSY; it completes and commits normally.
REQ-024 HI/LO SHALL change only at a commit (REQ-015), a move-to (REQ-020) or reset; the outputs SHALL never expose a partial result.

Reset
REQ-025 On a reset edge (reset==0), regardless of state, the block SHALL set state=IDLE, cnt=0, busy=0, HI=0, LO=0, pHI=0, pLO=0. An in-flight operation SHALL be abandoned with no commit.
REQ-026 The first edge with reset==1 SHALL accept a start or MDUwrite normally.

Verification
REQ-027 A=0xFFFFFFFE (-2), B=3, MDUcal=1, start for one cycle -> busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; with MDUcal=2 -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-028 A=0xFFFFFFF9 (-7), B=2, MDUcal=3 -> busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF; with MDUcal=4 -> LO=0x7FFFFFFC, HI=0x00000001.
REQ-029 HI=LO=0x12345678 preloaded via MDUwrite, then a div with B=0 -> 10 busy cycles, HI/LO still 0x12345678; then INT_MIN/-1 signed -> LO=0x80000000, HI=0.
REQ-030 Start a mult; during busy cycle 2 drive start with new operands and MDUwrite=1 -> both ignored, only the first result commits.
REQ-031 start with IntReq=1 -> busy stays 0, HI/LO unchanged. In a separate case, reset==0 during busy cycle 3 of a div -> next cycle busy=0, HI=LO=0, and no later commit occurs.
